// File: rtl/load_store_queue.sv
// In-order load/store queue that feeds the data-memory read/write unit. It captures pending
// operands off the CDB and squashes wrong-path entries after a mispredicted branch.

package load_store_queue_pkg;
   typedef logic [31:0] word32_t;
   typedef logic [3:0]  rs_tag_t;

   localparam rs_tag_t NO_VAL = 4'd0;

   typedef struct packed {
      rs_tag_t tag;
      word32_t val;
   } cdb_t;
endpackage

module load_store_queue
   import load_store_queue_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic    clk_i,
   input  logic    reset_n_i,
   input  logic    disp_valid_i,
   input  logic    disp_load_i,
   input  word32_t disp_base_i,
   input  rs_tag_t disp_base_tag_i,
   input  word32_t disp_offset_i,
   input  word32_t disp_st_data_i,
   input  rs_tag_t disp_st_tag_i,
   input  rs_tag_t disp_ld_tag_i,
   input  logic    br_dispatch_i,
   input  logic    br_resolve_i,
   input  logic    br_correct_i,
   input  cdb_t    cdb_i,
   input  logic    lsu_read_i,
   output logic    lsq_full_o,
   output logic    br_pending_o,
   output logic    lsu_empty_o,
   output word32_t lsu_eff_addr_o,
   output word32_t lsu_st_data_o,
   output rs_tag_t lsu_ld_tag_o,
   output logic    lsu_load_o,
   output logic    lsu_instr_ready_o,
   output logic    lsu_specultative_o,
   output logic    lsu_corr_pred_o
);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   // Entry storage; validity is implied by the head/count window.
   logic    ent_load     [DEPTH];
   word32_t ent_base     [DEPTH];
   rs_tag_t ent_base_tag [DEPTH];
   word32_t ent_offset   [DEPTH];
   word32_t ent_st_data  [DEPTH];
   rs_tag_t ent_st_tag   [DEPTH];
   rs_tag_t ent_ld_tag   [DEPTH];
   logic    ent_spec     [DEPTH];

   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   ptr_t spec_start_q, spec_start_d;
   cnt_t count_q, count_d;
   cnt_t spec_cnt_q, spec_cnt_d;
   logic spec_active_q, spec_active_d;

   logic    full, empty;
   logic    head_spec, head_ready;
   logic    pop, push, resolve, flush, commit, new_spec;
   logic    cdb_hit, base_match, st_match;
   word32_t new_base, new_st_data;
   rs_tag_t new_base_tag, new_st_tag;

   always_comb begin
      full       = (count_q == cnt_t'(DEPTH));
      empty      = (count_q == '0);
      head_spec  = ent_spec[head_q];
      head_ready = !empty && (ent_base_tag[head_q] == NO_VAL) &&
                   (ent_load[head_q] || (ent_st_tag[head_q] == NO_VAL)) &&
                   (!head_spec || br_resolve_i);

      pop      = lsu_read_i && head_ready;
      resolve  = br_resolve_i && spec_active_q;
      flush    = resolve && !br_correct_i;
      commit   = resolve && br_correct_i;
      // Fullness is judged before the pop; a push in a flush cycle is wrong-path work.
      push     = disp_valid_i && !full && !flush;
      new_spec = spec_active_q && !resolve;

      cdb_hit      = (cdb_i.tag != NO_VAL);
      base_match   = cdb_hit && (disp_base_tag_i == cdb_i.tag);
      st_match     = cdb_hit && (disp_st_tag_i == cdb_i.tag);
      new_base     = base_match ? cdb_i.val : disp_base_i;
      new_base_tag = base_match ? NO_VAL : disp_base_tag_i;
      new_st_data  = st_match ? cdb_i.val : disp_st_data_i;
      new_st_tag   = st_match ? NO_VAL : disp_st_tag_i;
   end

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      spec_cnt_d    = spec_cnt_q;
      spec_active_d = spec_active_q;
      spec_start_d  = spec_start_q;

      if (flush) begin
         // A popped speculative head is already gone with the flushed tail segment.
         head_d  = head_q + ptr_t'(pop && !head_spec);
         tail_d  = spec_start_q;
         count_d = count_q - spec_cnt_q - cnt_t'(pop && !head_spec);
      end else begin
         head_d  = head_q + ptr_t'(pop);
         tail_d  = tail_q + ptr_t'(push);
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end

      if (resolve) begin
         spec_cnt_d    = '0;
         spec_active_d = 1'b0;
      end else if (push && new_spec) begin
         spec_cnt_d = spec_cnt_q + cnt_t'(1);
      end

      // An op dispatched alongside the branch is older, so the window starts after it.
      if (br_dispatch_i) begin
         spec_active_d = 1'b1;
         spec_start_d  = tail_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         spec_cnt_q    <= '0;
         spec_active_q <= 1'b0;
         spec_start_q  <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         spec_cnt_q    <= spec_cnt_d;
         spec_active_q <= spec_active_d;
         spec_start_q  <= spec_start_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (cdb_hit && (ent_base_tag[ptr_t'(i)] == cdb_i.tag)) begin
            ent_base[ptr_t'(i)]     <= cdb_i.val;
            ent_base_tag[ptr_t'(i)] <= NO_VAL;
         end
         if (cdb_hit && (ent_st_tag[ptr_t'(i)] == cdb_i.tag)) begin
            ent_st_data[ptr_t'(i)] <= cdb_i.val;
            ent_st_tag[ptr_t'(i)]  <= NO_VAL;
         end
         if (commit) begin
            ent_spec[ptr_t'(i)] <= 1'b0;
         end
      end
      if (push) begin
         ent_load[tail_q]     <= disp_load_i;
         ent_base[tail_q]     <= new_base;
         ent_base_tag[tail_q] <= new_base_tag;
         ent_offset[tail_q]   <= disp_offset_i;
         ent_st_data[tail_q]  <= new_st_data;
         ent_st_tag[tail_q]   <= new_st_tag;
         ent_ld_tag[tail_q]   <= disp_ld_tag_i;
         ent_spec[tail_q]     <= new_spec;
      end
   end

   always_comb begin
      lsq_full_o         = full;
      lsu_empty_o        = empty;
      br_pending_o       = spec_active_q;
      lsu_eff_addr_o     = ent_base[head_q] + ent_offset[head_q];
      lsu_st_data_o      = ent_st_data[head_q];
      lsu_ld_tag_o       = ent_ld_tag[head_q];
      lsu_load_o         = ent_load[head_q];
      lsu_instr_ready_o  = head_ready;
      lsu_specultative_o = !empty && head_spec;
      lsu_corr_pred_o    = br_correct_i;
   end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- In-order queue of memory operations that feeds dmem_read_write_unit.
- Accepts loads and stores from dispatch with possibly-pending base and store-data operands, and snoops the CDB to capture them.
- Presents the oldest entry, with its effective address, data, tag and speculation status, in the lsu_* format the read/write unit consumes.
- Tracks one level of branch speculation and flushes wrong-path entries.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), pointer width (derived, not overridable).

Ports:
clk_i  input  1  clock
reset_n_i  input  1  synchronous reset, active-low
disp_valid_i  input  1  dispatch a memory op this cycle
disp_load_i  input  1  1 = load, 0 = store
disp_base_i  input  word32_t  base value; valid only when disp_base_tag_i == NO_VAL
disp_base_tag_i  input  rs_tag_t  producer tag of base, NO_VAL if ready
disp_offset_i  input  word32_t  sign-extended immediate
disp_st_data_i  input  word32_t  store data; valid only when disp_st_tag_i == NO_VAL
disp_st_tag_i  input  rs_tag_t  producer tag of store data, NO_VAL if ready; ignored for loads
disp_ld_tag_i  input  rs_tag_t  tag the load result is broadcast under
br_dispatch_i  input  1  a branch is dispatched this cycle
br_resolve_i  input  1  the outstanding branch resolves this cycle
br_correct_i  input  1  resolution outcome; 1 = predicted correctly
cdb_i  input  cdb_t  common data bus snoop
lsu_read_i  input  1  pop the head (from read/write unit)
lsq_full_o  output  1  no free entry
br_pending_o  output  1  a branch is outstanding
lsu_empty_o  output  1  no valid entry
lsu_eff_addr_o  output  word32_t  head base + offset
lsu_st_data_o  output  word32_t  head store data
lsu_ld_tag_o  output  rs_tag_t  head load tag
lsu_load_o  output  1  head is a load
lsu_instr_ready_o  output  1  head operands complete and issuable
lsu_specultative_o  output  1  head is on the speculative path
lsu_corr_pred_o  output  1  equals br_correct_i

Behaviour:
- Reset (reset_n_i low at a clock edge): head = tail = 0, count = 0, spec_active = 0.
  - Outputs after reset: lsu_empty_o = 1, lsu_full_o = 0, br_pending_o = 0, lsu_instr_ready_o = 0.
  - Reset mid-operation discards all entries; no partial state survives.
- Circular buffer with head/tail pointers of PTR_W bits that wrap modulo DEPTH, plus a separate count of PTR_W+1 bits.
  - lsq_full_o = (count == DEPTH); lsu_empty_o = (count == 0).
- Dispatch: when disp_valid_i and not full, the entry is written at tail and tail advances.
  - Dispatch while full is ignored; upstream stalls on lsq_full_o.
- Same-cycle pop and push while full is not allowed: a push is accepted only when count < DEPTH, judged before the pop.
- Operand capture:
  - Each cycle, every valid entry whose base_tag or st_tag equals cdb_i.tag (and cdb_i.tag != NO_VAL) latches cdb_i.val and sets that tag to NO_VAL.
  - A dispatching op whose tag equals cdb_i.tag in the same cycle captures cdb_i.val directly and is written as ready.
- Head outputs are combinational from the head entry.
  - lsu_eff_addr_o = base + offset, 32-bit wraparound add.
  - When empty, data outputs are don't-care and lsu_instr_ready_o = 0.
- Ready rule: lsu_instr_ready_o = valid, AND base_tag == NO_VAL, AND (load or st_tag == NO_VAL), AND (~spec or br_resolve_i).
  - The read/write unit therefore only ever sees a speculative head in the resolve cycle. It pops the head; if lsu_corr_pred_o = 0 it drops the op.
- Speculation:
  - br_dispatch_i sets spec_active and records spec_start = tail.
  - A memory op dispatched in the same cycle as the branch is older than the branch, so it is non-speculative and spec_start = tail + 1.
  - While spec_active, dispatched entries get spec = 1.
  - br_pending_o = spec_active; upstream never dispatches a second branch while it is high.
- Resolve correct (br_resolve_i & br_correct_i): clear every spec bit and spec_active. An op dispatched in the same cycle is non-speculative.
- Resolve mispredict (br_resolve_i & ~br_correct_i): tail <= spec_start, count recomputed, spec_active cleared.
  - An op dispatched in that same cycle is discarded.
  - If the popped head was speculative that cycle, head does not advance: the flush already removed it, leaving the queue empty.
  - A popped non-speculative head advances normally.
- br_resolve_i with no outstanding branch is ignored.
- lsu_read_i while empty or not ready is ignored.
- CDB capture and pop in the same cycle on the head entry: the pop wins, and the captured value is not needed.

Test Plan:
- Reset with reset_n_i = 0 for 2 cycles -> lsu_empty_o = 1, lsq_full_o = 0, lsu_instr_ready_o = 0, br_pending_o = 0.
- Dispatch a load with base 0x1000 ready, offset 0xFFFFFFFC, tag 5 -> next cycle lsu_eff_addr_o = 0x00000FFC, lsu_load_o = 1, lsu_ld_tag_o = 5, ready = 1; pop -> empty.
- Dispatch a store with st_tag 3 pending; later cdb_i = {3, 0xDEADBEEF} -> ready goes high the following cycle, lsu_st_data_o = 0xDEADBEEF. Repeat with the CDB match in the dispatch cycle -> ready the next cycle.
- Dispatch DEPTH = 8 ops with no pops -> lsq_full_o = 1 and a 9th dispatch is ignored. Pop one, dispatch one, then drain -> pointers wrap and program order is preserved.
- Dispatch ld A, then branch plus ld B in the same cycle, then st C and ld D.
  - Mispredict -> only A and B remain, count = 2.
  - Repeat with br_correct_i = 1 -> all four remain with spec = 0.
- Head speculative and ready, with lsu_read_i and mispredict in the same cycle -> lsu_corr_pred_o = 0, and the queue is empty next cycle with head == tail.
